// File: rtl/vram_scanout.sv
// 640x480@60 scan-out from a 320x240 RGB332 framebuffer, 2x2 pixel replication, 2-cycle pipeline.
// Optional colour-bar generator is enabled by defining TEST_PATTERN_EN (adds pattern_sel input).
module vram_scanout #(
  parameter int unsigned H_ACTIVE    = 640,
  parameter int unsigned H_FP        = 16,
  parameter int unsigned H_SYNC      = 96,
  parameter int unsigned H_BP        = 48,
  parameter int unsigned V_ACTIVE    = 480,
  parameter int unsigned V_FP        = 10,
  parameter int unsigned V_SYNC      = 2,
  parameter int unsigned V_BP        = 33,
  parameter int unsigned SCALE_SHIFT = 1,
  parameter int unsigned ADDR_W      = 17
) (
  input  logic              pixclk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [7:0]        wr_data,
`ifdef TEST_PATTERN_EN
  input  logic              pattern_sel,
`endif
  output logic [7:0]        red,
  output logic [7:0]        green,
  output logic [7:0]        blue,
  output logic              hSync,
  output logic              vSync,
  output logic              DrawArea,
  output logic              frame_start
);

  localparam int unsigned H_TOTAL    = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL    = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned X_W        = $clog2(H_TOTAL);
  localparam int unsigned Y_W        = $clog2(V_TOTAL);
  localparam int unsigned FB_W       = H_ACTIVE >> SCALE_SHIFT;
  localparam int unsigned FB_H       = V_ACTIVE >> SCALE_SHIFT;
  localparam int unsigned FB_SIZE    = FB_W * FB_H;
  localparam int unsigned SCALE_MASK = (1 << SCALE_SHIFT) - 1;
  localparam int unsigned HS_START   = H_ACTIVE + H_FP;
  localparam int unsigned HS_END     = H_ACTIVE + H_FP + H_SYNC;
  localparam int unsigned VS_START   = V_ACTIVE + V_FP;
  localparam int unsigned VS_END     = V_ACTIVE + V_FP + V_SYNC;

  // stage 0: counters and line base
  logic [X_W-1:0]    x_q, x_d;
  logic [Y_W-1:0]    y_q, y_d;
  logic [ADDR_W-1:0] line_base_q, line_base_d;
  logic [ADDR_W-1:0] rd_addr_c, rd_idx_c;
  logic              de0_c, hs0_c, vs0_c, fs0_c, x_wrap_c;

  // stage 1: registered BRAM read plus delayed control
  logic [7:0]        rd_data_q;
  logic              de1_q, de1_d, hs1_q, hs1_d, vs1_q, vs1_d, fs1_q, fs1_d;

  // stage 2: output registers
  logic [7:0]        red_q, red_d, green_q, green_d, blue_q, blue_d;
  logic              hs2_q, hs2_d, vs2_q, vs2_d, de2_q, de2_d, fs2_q, fs2_d;

  logic [7:0]        fb_mem [FB_SIZE];

  always_comb begin
    x_wrap_c    = (x_q == X_W'(H_TOTAL - 1));
    x_d         = x_q + X_W'(1);
    y_d         = y_q;
    line_base_d = line_base_q;
    if (x_wrap_c) begin
      x_d = '0;
      y_d = (y_q == Y_W'(V_TOTAL - 1)) ? '0 : y_q + Y_W'(1);
    end
    // advance one framebuffer row after the last replicated screen line of it
    if (x_wrap_c && ((y_q & Y_W'(SCALE_MASK)) == Y_W'(SCALE_MASK)) && (y_q < Y_W'(V_ACTIVE)))
      line_base_d = line_base_q + ADDR_W'(FB_W);
    else if (y_q == '0)
      line_base_d = '0;

    rd_addr_c = line_base_q + ADDR_W'(x_q >> SCALE_SHIFT);
    rd_idx_c  = (rd_addr_c < ADDR_W'(FB_SIZE)) ? rd_addr_c : '0;
    de0_c     = (x_q < X_W'(H_ACTIVE)) && (y_q < Y_W'(V_ACTIVE));
    hs0_c     = (x_q >= X_W'(HS_START)) && (x_q < X_W'(HS_END));
    vs0_c     = (y_q >= Y_W'(VS_START)) && (y_q < Y_W'(VS_END));
    fs0_c     = (x_q == '0) && (y_q == '0);
  end

`ifdef TEST_PATTERN_EN
  localparam int unsigned BAR_W = H_ACTIVE / 8;
  logic [2:0] bar0_c, bar1_q, bar1_d;

  always_comb begin
    bar0_c = '0;
    for (int k = 1; k < 8; k++)
      if (x_q >= X_W'(k * BAR_W)) bar0_c = 3'(k);
    bar1_d = bar0_c;
  end
`endif

  always_comb begin
    de1_d = de0_c;
    hs1_d = hs0_c;
    vs1_d = vs0_c;
    fs1_d = fs0_c;

    hs2_d = hs1_q;
    vs2_d = vs1_q;
    de2_d = de1_q;
    fs2_d = fs1_q;
    red_d   = '0;
    green_d = '0;
    blue_d  = '0;
    if (de1_q) begin
      red_d   = {rd_data_q[7:5], rd_data_q[7:5], rd_data_q[7:6]};
      green_d = {rd_data_q[4:2], rd_data_q[4:2], rd_data_q[4:3]};
      blue_d  = {4{rd_data_q[1:0]}};
`ifdef TEST_PATTERN_EN
      // bar order white,yellow,cyan,green,magenta,red,blue,black maps to inverted index bits
      if (pattern_sel) begin
        red_d   = {8{~bar1_q[1]}};
        green_d = {8{~bar1_q[2]}};
        blue_d  = {8{~bar1_q[0]}};
      end
`endif
    end
  end

  // framebuffer: read-before-write on same-address collisions
  always_ff @(posedge pixclk) begin
    if (wr_en && (wr_addr < ADDR_W'(FB_SIZE)))
      fb_mem[wr_addr] <= wr_data;
    if (rst) rd_data_q <= '0;
    else     rd_data_q <= fb_mem[rd_idx_c];
  end

  always_ff @(posedge pixclk) begin
    if (rst) begin
      x_q         <= '0;
      y_q         <= '0;
      line_base_q <= '0;
      de1_q       <= 1'b0;
      hs1_q       <= 1'b0;
      vs1_q       <= 1'b0;
      fs1_q       <= 1'b0;
      red_q       <= '0;
      green_q     <= '0;
      blue_q      <= '0;
      hs2_q       <= 1'b0;
      vs2_q       <= 1'b0;
      de2_q       <= 1'b0;
      fs2_q       <= 1'b0;
`ifdef TEST_PATTERN_EN
      bar1_q      <= '0;
`endif
    end else begin
      x_q         <= x_d;
      y_q         <= y_d;
      line_base_q <= line_base_d;
      de1_q       <= de1_d;
      hs1_q       <= hs1_d;
      vs1_q       <= vs1_d;
      fs1_q       <= fs1_d;
      red_q       <= red_d;
      green_q     <= green_d;
      blue_q      <= blue_d;
      hs2_q       <= hs2_d;
      vs2_q       <= vs2_d;
      de2_q       <= de2_d;
      fs2_q       <= fs2_d;
`ifdef TEST_PATTERN_EN
      bar1_q      <= bar1_d;
`endif
    end
  end

  assign red         = red_q;
  assign green       = green_q;
  assign blue        = blue_q;
  assign hSync       = hs2_q;
  assign vSync       = vs2_q;
  assign DrawArea    = de2_q;
  assign frame_start = fs2_q;

endmodule

// File: tb/tb_vram_scanout.sv
// Scoreboard bench for vram_scanout: a reference model predicts every output cycle,
// plus directed timing, pixel-replication, collision and mid-frame reset checks.
module tb_vram_scanout;

  logic        pixclk = 1'b0;
  logic        rst;
  logic        wr_en;
  logic [16:0] wr_addr;
  logic [7:0]  wr_data;
  logic [7:0]  red, green, blue;
  logic        hSync, vSync, DrawArea, frame_start;
`ifdef TEST_PATTERN_EN
  logic        pattern_sel;
`endif

  vram_scanout dut (
    .pixclk      (pixclk),
    .rst         (rst),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
`ifdef TEST_PATTERN_EN
    .pattern_sel (pattern_sel),
`endif
    .red         (red),
    .green       (green),
    .blue        (blue),
    .hSync       (hSync),
    .vSync       (vSync),
    .DrawArea    (DrawArea),
    .frame_start (frame_start)
  );

  always #20 pixclk = ~pixclk;

  typedef struct {
    int         x;
    logic       de, hs, vs, fs, known;
    logic [7:0] r, g, b;
  } exp_t;

  int         n_tests = 0;
  int         n_fail  = 0;
  exp_t       sb_q[$];
  exp_t       exp_cur;
  exp_t       zero_e;
  bit         have_exp = 0;
  int         mx = 0, my = 0;
  logic [7:0] m_mem [76800];
  bit         m_known [76800];
  bit         coll_done = 0;
  logic [23:0] bar_rgb [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                               24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t predict(input int x, input int y);
    exp_t e;
    int a;
    logic [7:0] px;
    e = zero_e;
    e.x  = x;
    e.de = (x < 640) && (y < 480);
    e.hs = (x >= 656) && (x < 752);
    e.vs = (y >= 490) && (y < 492);
    e.fs = (x == 0) && (y == 0);
    if (e.de) begin
      a  = (y / 2) * 320 + x / 2;
      px = m_mem[a];
      e.known = m_known[a];
      e.r = {px[7:5], px[7:5], px[7:6]};
      e.g = {px[4:2], px[4:2], px[4:3]};
      e.b = {px[1:0], px[1:0], px[1:0], px[1:0]};
    end
    return e;
  endfunction

  // reference model: advances on each rising edge using the inputs the DUT sees
  always @(posedge pixclk) begin
    if (rst) begin
      sb_q.delete();
      sb_q.push_back(zero_e);
      exp_cur = zero_e;
      mx = 0;
      my = 0;
    end else begin
      sb_q.push_back(predict(mx, my));
      exp_cur = sb_q.pop_front();
`ifdef TEST_PATTERN_EN
      if (pattern_sel && exp_cur.de) begin
        {exp_cur.r, exp_cur.g, exp_cur.b} = bar_rgb[exp_cur.x / 80];
        exp_cur.known = 1'b1;
      end
`endif
      if (mx == 799) begin
        mx = 0;
        my = (my == 524) ? 0 : my + 1;
      end else begin
        mx = mx + 1;
      end
    end
    if (wr_en && (wr_addr < 17'd76800)) begin
      m_mem[wr_addr]   = wr_data;
      m_known[wr_addr] = 1'b1;
    end
    have_exp = 1'b1;
  end

  always @(negedge pixclk) begin
    if (have_exp) begin
      check("DrawArea", 32'(DrawArea), 32'(exp_cur.de));
      check("hSync", 32'(hSync), 32'(exp_cur.hs));
      check("vSync", 32'(vSync), 32'(exp_cur.vs));
      check("frame_start", 32'(frame_start), 32'(exp_cur.fs));
      if (exp_cur.known) begin
        check("red", 32'(red), 32'(exp_cur.r));
        check("green", 32'(green), 32'(exp_cur.g));
        check("blue", 32'(blue), 32'(exp_cur.b));
      end
    end
  end

  // one clock: wait for the falling edge, then drive the write port for the next edge
  task automatic tick();
    @(negedge pixclk);
`ifdef TEST_PATTERN_EN
    pattern_sel = (my >= 8) && (my < 10);
`endif
    if (mx == 20 && my == 4 && !coll_done) begin
      wr_en = 1'b1; wr_addr = 17'd650; wr_data = 8'hA5; coll_done = 1'b1;
    end else if (mx == 100 && my == 2) begin
      wr_en = 1'b1; wr_addr = 17'd76800; wr_data = 8'hFF;
    end else if ($urandom_range(0, 1) == 1) begin
      wr_en = 1'b1; wr_addr = 17'($urandom_range(1000, 4799)); wr_data = 8'($urandom);
    end else begin
      wr_en = 1'b0;
    end
  endtask

  task automatic wait_fs(input string tag);
    int n;
    bit found;
    found = 0;
    n = 0;
    for (int i = 1; i <= 6; i++) begin
      tick();
      if (frame_start) begin
        found = 1;
        n = i;
        break;
      end
    end
    check(tag, 32'(found ? n : -1), 32'd2);
  endtask

  // step until the DUT outputs screen pixel (x,y), i.e. the counters hold (x+2,y)
  task automatic wait_pix(input int x, input int y, input string tag);
    bit found;
    found = 0;
    for (int i = 0; i < 90000; i++) begin
      if (mx == x + 2 && my == y) begin
        found = 1;
        break;
      end
      tick();
    end
    if (!found) check(tag, 32'd0, 32'd1);
  endtask

  initial begin
    int de_cnt, hs_cnt, hs_first;
    zero_e = '{x: 0, de: 0, hs: 0, vs: 0, fs: 0, known: 1, r: 0, g: 0, b: 0};
    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
`ifdef TEST_PATTERN_EN
    pattern_sel = 1'b0;
`endif
    @(negedge pixclk); wr_en = 1'b1; wr_addr = 17'd0;     wr_data = 8'hE0;
    @(negedge pixclk); wr_addr = 17'd321;   wr_data = 8'h1C;
    @(negedge pixclk); wr_addr = 17'd650;   wr_data = 8'h5A;
    @(negedge pixclk); wr_addr = 17'd76800; wr_data = 8'hFF;
    @(negedge pixclk); wr_en = 1'b0; rst = 1'b0;

    wait_fs("fs_after_reset");
    check("px00_red", 32'(red), 32'hFF);
    check("px00_green", 32'(green), 32'h00);

    de_cnt = 0; hs_cnt = 0; hs_first = -1;
    for (int i = 0; i < 800; i++) begin
      if (i > 0) tick();
      if (DrawArea) de_cnt++;
      if (hSync) begin
        hs_cnt++;
        if (hs_first < 0) hs_first = i;
      end
    end
    check("de_per_line", 32'(de_cnt), 32'd640);
    check("hs_width", 32'(hs_cnt), 32'd96);
    check("hs_start", 32'(hs_first), 32'd656);

    wait_pix(1, 1, "reach_1_1");
    check("px11_red", 32'(red), 32'hFF);
    check("px11_green", 32'(green), 32'h00);
    wait_pix(2, 2, "reach_2_2");
    check("px22_red", 32'(red), 32'h00);
    check("px22_green", 32'(green), 32'hFF);
    wait_pix(3, 3, "reach_3_3");
    check("px33_green", 32'(green), 32'hFF);
    wait_pix(20, 4, "reach_20_4");
    check("coll_old_red", 32'(red), 32'h49);
    wait_pix(20, 5, "reach_20_5");
    check("coll_new_red", 32'(red), 32'hB6);

    wait_pix(298, 100, "reach_mid_frame");
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_DrawArea", 32'(DrawArea), 32'd0);
    check("rst_red", 32'(red), 32'd0);
    wait_fs("fs_after_mid_reset");
    repeat (900) tick();
    wr_en = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
